lbdr_pkt_router: RTL and testbench
==================================

Name: lbdr_pkt_router

Overview:
Parametrised Logic-Based Distributed Routing (LBDR) unit for one router input port in a 2D mesh. It has configurable coordinate widths and configurable flit-ID encodings. A packet FSM computes the output-port vector once per HEADER flit and holds it until that packet's TAIL flit. It also provides error flagging and a packet counter. It sits between the input FIFO and the switch allocator.

Parameters:
X_W, 2, width of the X coordinate field (dst/cur address bits [X_W-1:0]).
Y_W, 2, width of the Y coordinate field (address bits [X_W+Y_W-1:X_W]).
FID_W, 3, width of flit_id.
HEADER_ID, 3'b001, flit_id value of a header flit.
TAIL_ID, 3'b100, flit_id value of a tail flit.
CNT_W, 8, width of pkt_cnt.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_rxy  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}; sampled only while rst=1
cfg_cx  in  4  connectivity bits {Cs,Cw,Ce,Cn}; sampled only while rst=1
cfg_cur_addr  in  X_W+Y_W  this router's address; sampled only while rst=1
flit_valid  in  1  flit present at FIFO head (equivalent to ~empty)
flit_id  in  FID_W  type of the head flit
dst_addr  in  X_W+Y_W  destination address; meaningful only on header flits
port  out  5  output request vector {L,S,W,E,N}
route_valid  out  1  port holds a live route for the current packet
route_err  out  1  one-cycle pulse on an unroutable header or a protocol error
pkt_cnt  out  CNT_W  number of headers accepted; wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous and active-high (clock clk, reset rst):
  - config registers load from the cfg_* inputs;
  - port=0, route_valid=0, route_err=0, pkt_cnt=0, FSM goes to IDLE.
- Reset takes priority over all other activity, including mid-packet; an in-flight packet is abandoned.
- Comparators are unsigned, on the registered cur address against dst_addr:
  - N1 = y_dst < y_cur;
  - S1 = y_cur < y_dst;
  - E1 = x_cur < x_dst;
  - W1 = x_dst < x_cur.
- Route function:
  - N = ((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw)) & Cn.
  - E, W and S follow the same form with their own bits (Ren/Res, Rwn/Rws, Rse/Rsw) and Cx bits.
  - L = ~N1&~E1&~W1&~S1.
  - A result with more than one bit set is a legal fork; it is passed through unchanged.
- FSM has two states, IDLE and HOLD.
- In IDLE, on flit_valid & flit_id==HEADER_ID:
  - If the route is nonzero: port is registered with the route, route_valid=1, pkt_cnt increments, next state HOLD. Latency is 1 cycle from header to port.
  - If the route is zero (destination unreachable): route_err pulses, port stays 0, pkt_cnt increments, state stays IDLE.
- In IDLE, a non-header valid flit pulses route_err; no other state changes.
- In HOLD:
  - port and route_valid are held for payload flits and while flit_valid=0; dst_addr is ignored.
  - On flit_valid & flit_id==TAIL_ID: port clears to 0 and route_valid clears to 0 on the next cycle, next state IDLE.
- A header received in HOLD (missing tail):
  - route_err pulses;
  - the new header is routed as it would be in IDLE, and pkt_cnt increments;
  - the FSM stays in HOLD if the new route is nonzero, otherwise it goes to IDLE.
- A flit that is both header and tail (when HEADER_ID==TAIL_ID is not used): single-flit packets are not supported; the encodings must differ.
- route_err is high for exactly one cycle per event.

Optional Feature:
Macro LBDR_DEROUTE_EN.
- Defined:
  - Adds input cfg_dr [7:0]: two-bit deroute port index per quadrant direction {S,W,E,N}, encoded 0=N, 1=E, 2=W, 3=S; sampled only while rst=1.
  - When a non-local header's minimal route is zero, the deroute index of the primary direction is used. The primary direction is N or S if the packet needs to move in Y, otherwise E or W.
  - That deroute port is used as the route if its Cx bit is 1; route_err pulses only if the deroute port is also disconnected.
- Undefined: cfg_dr is not present; an unroutable header always pulses route_err.

Test Plan:
1. Setup: rst with cfg_cur_addr=5, cfg_rxy=8'h3C, cfg_cx=4'hF. Header with dst=5 -> next cycle port=5'b10000, route_valid=1, pkt_cnt=1.
2. Same config, header with dst=0 (N1 and W1 both true, Rnw=0, Rwn=1) -> port=5'b00100. Then 3 payload flits with dst changing to 15 and gaps of flit_valid=0 -> port held at 5'b00100. Then a tail -> cycle after: port=0, route_valid=0.
3. rst with cfg_cx=4'b1011 (W disconnected), header with dst=4 -> route_err pulses 1 cycle, port=0, FSM stays IDLE.
   - With LBDR_DEROUTE_EN and cfg_dr selecting N for W -> port=5'b00001, no error.
4. Header dst=0 followed by a header dst=7 without a tail -> route_err pulse, port=5'b00010 (E), pkt_cnt increments by 2 overall.
5. rst asserted in HOLD -> next cycle all outputs 0. Reload with cfg_cur_addr=0, then header dst=5 -> port=5'b00010 only if Res=1, else 5'b01000 only if Rse=1.
6. CNT_W=2, 5 headers each followed by a tail -> pkt_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/lbdr_pkt_router_if.sv
// Flit-side and route-side signals of one LBDR router input port.
// flit_valid is a level (FIFO non-empty); the router only observes the head flit and
// never back-pressures it, so there is no ready. port/route_valid/route_err/pkt_cnt are registered.
interface lbdr_pkt_router_if #(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int FID_W = 3,
  parameter int CNT_W = 8
);
  logic                 flit_valid;
  logic [FID_W-1:0]     flit_id;
  logic [X_W+Y_W-1:0]   dst_addr;
  logic [4:0]           port;
  logic                 route_valid;
  logic                 route_err;
  logic [CNT_W-1:0]     pkt_cnt;

  modport master (
    output flit_valid, flit_id, dst_addr,
    input  port, route_valid, route_err, pkt_cnt
  );

  modport slave (
    input  flit_valid, flit_id, dst_addr,
    output port, route_valid, route_err, pkt_cnt
  );
endinterface

// File: rtl/lbdr_pkt_router.sv
// LBDR route computation for one mesh input port: route latched per header, held to tail.
// Optional macro LBDR_DEROUTE_EN adds cfg_dr and a fallback deroute port for unroutable headers.
module lbdr_pkt_router #(
  parameter int               X_W       = 2,
  parameter int               Y_W       = 2,
  parameter int               FID_W     = 3,
  parameter logic [FID_W-1:0] HEADER_ID = 3'b001,
  parameter logic [FID_W-1:0] TAIL_ID   = 3'b100,
  parameter int               CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cfg_rxy,
  input  logic [3:0]         cfg_cx,
  input  logic [X_W+Y_W-1:0] cfg_cur_addr,
`ifdef LBDR_DEROUTE_EN
  input  logic [7:0]         cfg_dr,
`endif
  lbdr_pkt_router_if.slave   bus,
  output logic               dbg_state
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [7:0]         rxy_q;
  logic [3:0]         cx_q;
  logic [X_W+Y_W-1:0] cur_q;
  logic [4:0]         port_q, port_d;
  logic               rv_q, rv_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [X_W-1:0]     x_cur, x_dst;
  logic [Y_W-1:0]     y_cur, y_dst;
  logic               n1, s1, e1, w1;
  logic [4:0]         min_route, route;
  logic               is_hdr, is_tail;

`ifdef LBDR_DEROUTE_EN
  logic [7:0]         dr_q;
  logic [1:0]         dr_sel;
`endif

  assign x_cur = cur_q[X_W-1:0];
  assign y_cur = cur_q[X_W+Y_W-1:X_W];
  assign x_dst = bus.dst_addr[X_W-1:0];
  assign y_dst = bus.dst_addr[X_W+Y_W-1:X_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  // Port bit order {L,S,W,E,N}; cx_q bit order {Cs,Cw,Ce,Cn} lines up with bits [3:0].
  assign min_route[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0]) | (n1 & w1 & rxy_q[1])) & cx_q[0];
  assign min_route[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2]) | (e1 & s1 & rxy_q[3])) & cx_q[1];
  assign min_route[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4]) | (w1 & s1 & rxy_q[5])) & cx_q[2];
  assign min_route[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6]) | (s1 & w1 & rxy_q[7])) & cx_q[3];
  assign min_route[4] = ~n1 & ~e1 & ~w1 & ~s1;

  always_comb begin
    route = min_route;
`ifdef LBDR_DEROUTE_EN
    // Primary direction is the Y move when one is needed, otherwise the X move.
    if (n1)      dr_sel = dr_q[1:0];
    else if (s1) dr_sel = dr_q[7:6];
    else if (e1) dr_sel = dr_q[3:2];
    else         dr_sel = dr_q[5:4];
    if (min_route == 5'b00000) route = {1'b0, (4'b0001 << dr_sel) & cx_q};
`endif
  end

  assign is_hdr  = bus.flit_valid && (bus.flit_id == HEADER_ID);
  assign is_tail = bus.flit_valid && (bus.flit_id == TAIL_ID);

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rv_d    = rv_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (is_hdr) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (route != 5'b00000) begin
            port_d  = route;
            rv_d    = 1'b1;
            state_d = HOLD;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.flit_valid) begin
          err_d = 1'b1;
        end
      end
      HOLD: begin
        if (is_hdr) begin
          // Missing tail: flag it, then route the new header as a fresh packet.
          err_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (route != 5'b00000) begin
            port_d = route;
            rv_d   = 1'b1;
          end else begin
            port_d  = 5'b00000;
            rv_d    = 1'b0;
            state_d = IDLE;
          end
        end else if (is_tail) begin
          port_d  = 5'b00000;
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_q   <= cfg_rxy;
      cx_q    <= cfg_cx;
      cur_q   <= cfg_cur_addr;
`ifdef LBDR_DEROUTE_EN
      dr_q    <= cfg_dr;
`endif
      state_q <= IDLE;
      port_q  <= 5'b00000;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.port        = port_q;
  assign bus.route_valid = rv_q;
  assign bus.route_err   = err_q;
  assign bus.pkt_cnt     = cnt_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_lbdr_pkt_router.sv
// Bench for lbdr_pkt_router: spec-level model compared every cycle plus literal pins.
// A second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_lbdr_pkt_router;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;
  localparam logic [2:0] PAY  = 3'b010;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_rxy;
  logic [3:0] cfg_cx;
  logic [3:0] cfg_cur_addr;
  logic [7:0] cfg_dr;
  logic       dbg_state, dbg_state2;

  int checks = 0;
  int errors = 0;

  lbdr_pkt_router_if #(.CNT_W(8)) bus ();
  lbdr_pkt_router_if #(.CNT_W(2)) bus2 ();

  assign bus2.flit_valid = bus.flit_valid;
  assign bus2.flit_id    = bus.flit_id;
  assign bus2.dst_addr   = bus.dst_addr;

  lbdr_pkt_router #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_cur_addr(cfg_cur_addr),
`ifdef LBDR_DEROUTE_EN
    .cfg_dr(cfg_dr),
`endif
    .bus(bus), .dbg_state(dbg_state)
  );

  lbdr_pkt_router #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_cur_addr(cfg_cur_addr),
`ifdef LBDR_DEROUTE_EN
    .cfg_dr(cfg_dr),
`endif
    .bus(bus2), .dbg_state(dbg_state2)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [7:0] m_rxy;
  logic [3:0] m_cx, m_cur;
  logic [7:0] m_dr;
  logic       m_on = 1'b0;
  logic       m_hold, m_rv, m_err;
  logic [4:0] m_port;
  int         m_cnt;

  function automatic logic [4:0] model_route(input logic [3:0] dst);
    int xc, yc, xd, yd, dx, dy, pd, idx;
    logic [4:0] r;
    xc = int'(m_cur[1:0]); yc = int'(m_cur[3:2]);
    xd = int'(dst[1:0]);   yd = int'(dst[3:2]);
    dx = xd - xc; dy = yd - yc;
    if (dx == 0 && dy == 0) return 5'b10000;
    r = 5'b00000;
    if (dy < 0 && m_cx[0] && (dx == 0 || (dx > 0 && m_rxy[0]) || (dx < 0 && m_rxy[1]))) r[0] = 1'b1;
    if (dx > 0 && m_cx[1] && (dy == 0 || (dy < 0 && m_rxy[2]) || (dy > 0 && m_rxy[3]))) r[1] = 1'b1;
    if (dx < 0 && m_cx[2] && (dy == 0 || (dy < 0 && m_rxy[4]) || (dy > 0 && m_rxy[5]))) r[2] = 1'b1;
    if (dy > 0 && m_cx[3] && (dx == 0 || (dx > 0 && m_rxy[6]) || (dx < 0 && m_rxy[7]))) r[3] = 1'b1;
`ifdef LBDR_DEROUTE_EN
    if (r == 5'b00000) begin
      pd  = (dy < 0) ? 0 : (dy > 0) ? 3 : (dx > 0) ? 1 : 2;
      idx = int'((m_dr >> (2 * pd)) & 8'h03);
      if (m_cx[idx]) r[idx] = 1'b1;
    end
`else
    pd = 0; idx = 0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    logic [4:0] r;
    if (rst) begin
      m_rxy = cfg_rxy; m_cx = cfg_cx; m_cur = cfg_cur_addr; m_dr = cfg_dr;
      m_hold = 1'b0; m_port = 5'b00000; m_rv = 1'b0; m_err = 1'b0; m_cnt = 0; m_on = 1'b1;
    end else if (m_on) begin
      m_err = 1'b0;
      if (bus.flit_valid && bus.flit_id == HDR) begin
        r = model_route(bus.dst_addr);
        m_cnt = m_cnt + 1;
        if (m_hold || r == 5'b00000) m_err = 1'b1;
        if (r != 5'b00000) begin
          m_port = r; m_rv = 1'b1; m_hold = 1'b1;
        end else begin
          m_port = 5'b00000; m_rv = 1'b0; m_hold = 1'b0;
        end
      end else if (bus.flit_valid && bus.flit_id == TAIL && m_hold) begin
        m_port = 5'b00000; m_rv = 1'b0; m_hold = 1'b0;
      end else if (bus.flit_valid && !m_hold) begin
        m_err = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      check("port",        32'(bus.port),        32'(m_port));
      check("route_valid", 32'(bus.route_valid), 32'(m_rv));
      check("route_err",   32'(bus.route_err),   32'(m_err));
      check("pkt_cnt",     32'(bus.pkt_cnt),     32'(m_cnt % 256));
      check("pkt_cnt_w2",  32'(bus2.pkt_cnt),    32'(m_cnt % 4));
      check("state",       32'(dbg_state),       32'(m_hold));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [3:0] cur, input logic [7:0] rxy, input logic [3:0] cx,
                          input logic [7:0] dr);
    rst = 1'b1;
    cfg_cur_addr = cur; cfg_rxy = rxy; cfg_cx = cx; cfg_dr = dr;
    bus.flit_valid = 1'b0; bus.flit_id = 3'b000; bus.dst_addr = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [2:0] id, input logic [3:0] d);
    bus.flit_valid = v; bus.flit_id = id; bus.dst_addr = d;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int         cnt_seq [5] = '{1, 2, 3, 0, 1};
  logic [3:0] sw_cur  [4] = '{4'd5, 4'd10, 4'd0, 4'd15};
  logic [7:0] sw_rxy  [4] = '{8'h3C, 8'hC3, 8'hA5, 8'h5A};
  logic [3:0] sw_cx   [4] = '{4'hF, 4'hF, 4'b0111, 4'b1010};

  initial begin
    // 1: local delivery and reset state
    do_reset(4'd5, 8'h3C, 4'hF, 8'hE4);
    check("rst_port", 32'(bus.port), 32'h0);
    check("rst_cnt",  32'(bus.pkt_cnt), 32'h0);
    drive(1'b1, HDR, 4'd5);
    check("t1_port", 32'(bus.port), 32'b10000);
    check("t1_rv",   32'(bus.route_valid), 32'h1);
    check("t1_cnt",  32'(bus.pkt_cnt), 32'h1);
    drive(1'b1, TAIL, 4'd0);
    check("t1_tail_port", 32'(bus.port), 32'h0);

    // 2: west route held across payload and gaps
    drive(1'b1, HDR, 4'd0);
    check("t2_port", 32'(bus.port), 32'b00100);
    drive(1'b1, PAY, 4'd15);
    drive(1'b0, PAY, 4'd15);
    drive(1'b1, PAY, 4'd15);
    drive(1'b0, 3'b000, 4'd7);
    drive(1'b1, PAY, 4'd15);
    check("t2_hold_port", 32'(bus.port), 32'b00100);
    check("t2_hold_rv",   32'(bus.route_valid), 32'h1);
    drive(1'b1, TAIL, 4'd15);
    check("t2_tail_port", 32'(bus.port), 32'h0);
    check("t2_tail_rv",   32'(bus.route_valid), 32'h0);
    drive(1'b0, 3'b000, 4'd0);

    // 3: west disconnected; deroute table sends W to N when enabled
    do_reset(4'd5, 8'h3C, 4'b1011, 8'hC4);
    drive(1'b1, HDR, 4'd4);
`ifdef LBDR_DEROUTE_EN
    check("t3_port", 32'(bus.port), 32'b00001);
    check("t3_err",  32'(bus.route_err), 32'h0);
    drive(1'b1, TAIL, 4'd0);
`else
    check("t3_port", 32'(bus.port), 32'h0);
    check("t3_err",  32'(bus.route_err), 32'h1);
    check("t3_cnt",  32'(bus.pkt_cnt), 32'h1);
    drive(1'b0, 3'b000, 4'd0);
    check("t3_err_pulse", 32'(bus.route_err), 32'h0);
`endif
    drive(1'b1, PAY, 4'd0);
    check("t3_idle_pay_err", 32'(bus.route_err), 32'h1);
    drive(1'b0, 3'b000, 4'd0);
    drive(1'b1, HDR, 4'd7);
    drive(1'b1, HDR, 4'd4);
    drive(1'b1, TAIL, 4'd0);
    drive(1'b0, 3'b000, 4'd0);

    // 4: header while holding (missing tail)
    do_reset(4'd5, 8'h3C, 4'hF, 8'hE4);
    drive(1'b1, HDR, 4'd0);
    drive(1'b1, HDR, 4'd7);
    check("t4_port", 32'(bus.port), 32'b00010);
    check("t4_err",  32'(bus.route_err), 32'h1);
    check("t4_cnt",  32'(bus.pkt_cnt), 32'h2);
    drive(1'b1, PAY, 4'd0);
    check("t4_err_pulse", 32'(bus.route_err), 32'h0);

    // 5: reset in HOLD, then reload at origin
    do_reset(4'd0, 8'h3C, 4'hF, 8'hE4);
    check("t5_rst_port", 32'(bus.port), 32'h0);
    check("t5_rst_rv",   32'(bus.route_valid), 32'h0);
    check("t5_rst_cnt",  32'(bus.pkt_cnt), 32'h0);
    drive(1'b1, HDR, 4'd5);
    check("t5_port", 32'(bus.port), 32'b00010);
    drive(1'b1, TAIL, 4'd0);

    // 6: 2-bit counter wrap
    do_reset(4'd5, 8'h3C, 4'hF, 8'hE4);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, HDR, 4'd5);
      check($sformatf("t6_cnt2_%0d", i), 32'(bus2.pkt_cnt), 32'(cnt_seq[i]));
      drive(1'b1, TAIL, 4'd0);
    end

    // sweep: every destination under a few configurations, model-checked
    for (int c = 0; c < 4; c++) begin
      do_reset(sw_cur[c], sw_rxy[c], sw_cx[c], 8'h1B);
      for (int d = 0; d < 16; d++) begin
        drive(1'b1, HDR, 4'(d));
        drive(1'b1, PAY, 4'(15 - d));
        drive(1'b1, TAIL, 4'(d));
      end
    end
    drive(1'b0, 3'b000, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
